// File: rtl/qp_fixed_pkg.sv
// Shared Q15.16 fixed-point definitions for the MAC and PDNN activation stages.
package qp_fixed_pkg;

  localparam int DATA_W    = 32;
  localparam int FRAC_DFLT = 16;

  typedef logic signed [DATA_W-1:0] q_t;

  // Clamp a wide signed value to the 32-bit Q range.
  function automatic q_t sat32(input logic signed [63:0] v);
    if (v > 64'sh0000_0000_7FFF_FFFF)
      return q_t'(32'h7FFF_FFFF);
    else if (v < 64'shFFFF_FFFF_8000_0000)
      return q_t'(32'h8000_0000);
    else
      return q_t'(v[DATA_W-1:0]);
  endfunction

endpackage

// File: rtl/qp_mac_accumulator_if.sv
// Term stream in, saturated result out, for the MAC accumulator.
interface qp_mac_accumulator_if;
  import qp_fixed_pkg::*;

  logic start;
  q_t   w;
  q_t   x;
  logic in_valid;
  logic in_ready;
  q_t   e;
  logic en;
  logic busy;

  modport master (
    output start, w, x, in_valid,
    input  in_ready, e, en, busy
  );

  modport slave (
    input  start, w, x, in_valid,
    output in_ready, e, en, busy
  );

endinterface

// File: rtl/qp_mac_accumulator.sv
// Fixed-point MAC: sums N_TERMS floor-shifted w*x products, saturates to 32 bits,
// and strobes en low for one cycle with the new result on e.
//
//   state | meaning
//   IDLE  | waiting for start, in_ready low
//   ACC   | accepting terms, one per valid cycle
//   OUT   | e is new and en is low for this cycle
module qp_mac_accumulator
  import qp_fixed_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int FRAC    = FRAC_DFLT,
  parameter int ACC_W   = 56
) (
  input logic clk,
  input logic rst,
  qp_mac_accumulator_if.slave bus
);

  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         count;
  logic signed [ACC_W-1:0]  acc;
  logic signed [63:0]       prod;
  logic signed [63:0]       prod_shr;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  sum;
  logic                     accept;

  assign prod     = $signed({{32{bus.w[31]}}, bus.w}) * $signed({{32{bus.x[31]}}, bus.x});
  assign prod_shr = prod >>> FRAC;
  assign term     = ACC_W'(prod_shr);
  assign sum      = acc + term;
  assign accept   = (state == ACC) && bus.in_valid;

  assign bus.in_ready = (state == ACC);
  assign bus.busy     = (state == ACC) || (state == OUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      bus.e  <= '0;
      bus.en <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc   <= '0;
            count <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          if (accept) begin
            acc   <= sum;
            count <= count + 1'b1;
            if (count == LAST) begin
              bus.e  <= sat32(64'(sum));
              bus.en <= 1'b0;
              state  <= OUT;
            end
          end
        end
        OUT: begin
          bus.en <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qp_mac_accumulator.sv
// Directed bench for qp_mac_accumulator with N_TERMS=4, Q15.16.
module tb_qp_mac_accumulator;
  import qp_fixed_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  qp_mac_accumulator_if bus();

  qp_mac_accumulator #(.N_TERMS(4), .FRAC(16), .ACC_W(56)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full accumulation of four identical terms with gap idle cycles between them.
  task automatic run_vector(input string tag, input logic [31:0] wv, input logic [31:0] xv,
                            input int gap, input logic [31:0] exp_e);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_in_ready_acc"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_busy_acc"}, 32'(bus.busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      bus.w = wv;
      bus.x = xv;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (i < 3) begin
        check({tag, "_en_mid"}, 32'(bus.en), 32'd1);
        for (int g = 0; g < gap; g++) @(negedge clk);
      end
    end
    check({tag, "_e"}, bus.e, exp_e);
    check({tag, "_en_low"}, 32'(bus.en), 32'd0);
    check({tag, "_in_ready_out"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_busy_out"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    check({tag, "_en_high"}, 32'(bus.en), 32'd1);
    check({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    check({tag, "_e_hold"}, bus.e, exp_e);
  endtask

  initial begin
    int first_pulse;
    int last_pulse;
    int n_pulse;
    int period_bad;

    bus.start    = 1'b0;
    bus.w        = '0;
    bus.x        = '0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_e", bus.e, 32'h0);
    check("rst_en", 32'(bus.en), 32'd1);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    run_vector("b2b", 32'h0001_0000, 32'h0002_0000, 0, 32'h0008_0000);
    run_vector("gap", 32'h0001_0000, 32'h0002_0000, 3, 32'h0008_0000);
    run_vector("neg", 32'hFFFE_8000, 32'h0000_8000, 0, 32'hFFFD_0000);
    // -1 LSB * 1 LSB floors to -1 per term; truncation toward zero would give 0.
    run_vector("floor", 32'hFFFF_FFFF, 32'h0000_0001, 0, 32'hFFFF_FFFC);
    run_vector("satp", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF);
    run_vector("satn", 32'h8000_0000, 32'h7FFF_FFFF, 0, 32'h8000_0000);

    // Reset mid-accumulation discards the partial sum.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.w = 32'h0001_0000;
    bus.x = 32'h0001_0000;
    bus.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_en", 32'(bus.en), 32'd1);
    check("midrst_e", bus.e, 32'h0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("midrst_en_after", 32'(bus.en), 32'd1);
    run_vector("postrst", 32'h0001_0000, 32'h0001_0000, 0, 32'h0004_0000);

    // start and in_valid held high: results every N_TERMS+2 cycles, no early restart.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.w        = 32'h0001_0000;
    bus.x        = 32'h0001_0000;
    first_pulse = -1;
    last_pulse  = -1;
    n_pulse     = 0;
    period_bad  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.en) begin
        check("held_e", bus.e, 32'h0004_0000);
        if (first_pulse < 0) first_pulse = i;
        else if (i - last_pulse != 6) period_bad++;
        last_pulse = i;
        n_pulse++;
      end
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check("held_first_pulse", 32'(first_pulse), 32'd4);
    check("held_pulse_count", 32'(n_pulse), 32'd3);
    check("held_period_errs", 32'(period_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qp_mac_accumulator.md
# qp_mac_accumulator

Fixed-point multiply-accumulate engine that produces the 32-bit signed accumulator result `e` consumed by the PDNN activation stage. For each neuron it accepts a stream of `N_TERMS` weight/state pairs and accumulates their Q-format products. It saturates the sum to 32 bits and presents it on `e` with a one-cycle active-low `en` strobe. The activation stage latches `e` while `en` is low and holds its output while `en` is high.

## Interface
- `N_TERMS`, 4: products accumulated per result; legal range 1..256.
- `FRAC`, 16: fractional bits of the Q format shared by `w`, `x` and `e` (Q15.16 by default).
- `ACC_W`, 56: internal accumulator width; must be ≥ 48 + clog2(`N_TERMS`).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a new accumulation; sampled only in IDLE.
- `w`  in  32  signed weight/coefficient term.
- `x`  in  32  signed state-vector term.
- `in_valid`  in  1  `w`/`x` valid this cycle.
- `in_ready`  out  1  block accepts a term this cycle; a term is accepted when `in_valid & in_ready`.
- `e`  out  32  signed saturated accumulation result, registered.
- `en`  out  1  active-low result strobe: low for exactly one cycle when `e` is new, otherwise high.
- `busy`  out  1  high in ACC and OUT.

## Operation
- States:
  - IDLE: `in_ready`=0.
  - ACC: `in_ready`=1.
  - OUT: `in_ready`=0, one cycle only.
- IDLE with `start`=1: clear `acc` and `count` to 0, go to ACC.
- ACC, on each accepted term:
  - `term` = (64-bit signed `w*x`) >>> `FRAC`, arithmetic shift (floor), sign-extended to `ACC_W`.
  - `acc` += `term`; `count` += 1.
  - `acc` wraps modulo 2^`ACC_W`; this cannot occur within the legal parameter range.
- Last term (`count` == `N_TERMS`-1 and accept), at the same edge:
  - `e` <= sat32(`acc` + `term`); `en` <= 0; state <= OUT.
  - sat32 clamps values above 2^31-1 to 0x7FFFFFFF and values below -2^31 to 0x80000000.
- OUT: at the next edge, `en` <= 1 and state <= IDLE.
- `start` asserted in ACC or OUT is ignored; it is not queued.
- No-accept cycles in ACC (`in_valid`=0) leave `acc`, `count` and the state unchanged. Gaps of any length are legal.
- `e` holds its last value until the next result.
- `N_TERMS`=1: the first accepted term goes directly to OUT.

## Timing
- Reset values: state IDLE, `acc`=0, `count`=0, `e`=0, `en`=1, `in_ready`=0, `busy`=0.
- `rst` overrides everything, including mid-ACC and in OUT. A partial sum is discarded and no `en` pulse is produced.
- `in_ready` is a registered-state decode; it is high from the cycle after `start` is sampled.
- Latency: `e` is valid and `en`=0 in the cycle immediately after the edge that accepts the last term.
- Throughput: one term per cycle.
- Minimum result period is `N_TERMS` + 2 cycles: start, `N_TERMS` accepts, OUT. A `start` in the cycle after OUT (back in IDLE) is accepted.
- The multiply-add path is single-cycle, with no pipeline stage.

## Structure
- Shared package `qp_fixed_pkg` holds:
  - `DATA_W`=32 and the default `FRAC`=16.
  - typedef `q_t` (signed [31:0]).
  - the sat32 function; the activation stages reuse it.
- State encoding is a local enum inside the module.
- No sub-module; a single always block for state, counter, accumulator and output registers.

## Test plan
- `N_TERMS`=4, four terms `w`=0x00010000 (1.0), `x`=0x00020000 (2.0), back-to-back -> `e`=0x00080000 one cycle after the 4th accept; `en` low exactly one cycle; `busy` falls the cycle after.
- Same stimulus with `in_valid` low 3 cycles between each term -> identical `e`; `en` timing relative to the last accept unchanged.
- Four terms `w`=0xFFFE8000 (-1.5), `x`=0x00008000 (0.5) -> `e`=0xFFFD0000 (-3.0), confirming sign and floor shift.
- Four terms `w`=`x`=0x7FFFFFFF -> `e`=0x7FFFFFFF. Four terms `w`=0x80000000, `x`=0x7FFFFFFF -> `e`=0x80000000.
- `rst` pulsed after 2 accepted terms -> `en` stays 1, `e`=0, `in_ready`=0. A following start with 4 × (1.0, 1.0) -> `e`=0x00040000.
- `start` held high throughout -> `start` pulses during ACC and OUT are ignored. A new accumulation begins only in the IDLE cycle after OUT; the result period is exactly `N_TERMS`+2 cycles.
